// File: rtl/ex_alu_md.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_md
// Purpose  : EX-stage ALU with a registered single-cycle path, plus an
//            iterative multiply/divide unit with HI/LO result registers
//            (MIPS mult/multu/div/divu).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  operand/result width (power of two, 8..64)
//   SHW    shift-amount width, derived from WIDTH
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   a, b, control       ALU operands and 3-bit op code
//   in_valid            operands valid this cycle
//   result, zero        registered ALU result and result==0 flag
//   out_valid           result/zero updated on the previous edge
//   md_start, md_op     start multiply/divide (00 mult, 01 multu,
//                       10 div, 11 divu); operands taken from a/b
//   md_busy, md_done    unit running / one-cycle completion pulse
//   hi, lo              HI/LO result registers
//   md_dbz              last divide had a zero divisor
// Build option
//   ALU_SHIFT_EN        enables SLL/SRL/SRA on codes 011/100/101;
//                       without it those codes yield result=0, zero=1
// ============================================================================
module ex_alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_dbz
);

  // ALU op codes
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_slt = 3'b111;
`ifdef ALU_SHIFT_EN
  localparam logic [2:0] c_alu_sll = 3'b011;
  localparam logic [2:0] c_alu_srl = 3'b100;
  localparam logic [2:0] c_alu_sra = 3'b101;
`endif

  // MD state encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;

  localparam logic [SHW-1:0] c_last_iter = SHW'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // ALU path
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_alu;
`ifdef ALU_SHIFT_EN
  logic [SHW-1:0]   w_shamt;
  assign w_shamt = a[SHW-1:0];
`endif

  always_comb begin
    w_alu = '0;
    case (control)
      c_alu_and: w_alu = a & b;
      c_alu_or:  w_alu = a | b;
      c_alu_add: w_alu = a + b;
      c_alu_sub: w_alu = a - b;
      c_alu_slt: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SHIFT_EN
      c_alu_sll: w_alu = b << w_shamt;
      c_alu_srl: w_alu = b >> w_shamt;
      c_alu_sra: w_alu = $signed(b) >>> w_shamt;
`endif
      default:   w_alu = '0;
    endcase
  end

  // Result and zero hold when no new operands arrive; out_valid tracks
  // in_valid one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= w_alu;
        zero   <= (w_alu == '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Multiply/divide unit
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [SHW-1:0]     r_count;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_m;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_p;       // {acc/remainder, multiplier/quotient}
  logic               r_neg_q;   // negate product or quotient in FIX
  logic               r_neg_r;   // negate remainder in FIX
  logic               r_dbz;     // current divide has a zero divisor

  logic               w_accept;
  logic               w_in_run;
  logic               w_in_fix;

  // Start-time operand conditioning (signed ops work on magnitudes)
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_zero;

  assign w_signed   = ~md_op[0];
  assign w_a_neg    = w_signed & a[WIDTH-1];
  assign w_b_neg    = w_signed & b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  assign w_div_zero = md_op[1] & (b == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a zero divisor bypasses the iterations entirely
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (md_start) w_next_state = w_div_zero ? c_st_fix : c_st_run;
      c_st_run:  if (r_count == c_last_iter) w_next_state = c_st_fix;
      c_st_fix:  w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // State decode; md_start outside IDLE (including FIX) is ignored
  always_comb begin
    md_busy  = (r_state != c_st_idle);
    w_accept = (r_state == c_st_idle) & md_start;
    w_in_run = (r_state == c_st_run);
    w_in_fix = (r_state == c_st_fix);
  end

  // Shift-add multiply step: conditionally add the multiplicand into the
  // upper half, then shift the whole product right by one. The carry bit
  // of the add drops into the top of the shifted product.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and trial-subtract. The remainder stays below the divisor,
  // so the shifted value always fits in WIDTH+1 bits and, when restored,
  // in WIDTH bits.
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_div_trial = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]} - {1'b0, r_m};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_p[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  // Sign correction applied on the FIX edge. The most-negative / -1 case
  // needs no special handling: the magnitude quotient 2^(WIDTH-1) is left
  // un-negated and already reads as the most-negative value.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  assign w_prod_fix = r_neg_q ? -r_p : r_p;
  assign w_quo_fix  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_op    <= 2'b00;
      r_m     <= '0;
      r_p     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      md_done <= 1'b0;
      md_dbz  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      md_done <= 1'b0;
      if (w_accept) begin
        r_op    <= md_op;
        r_count <= '0;
        r_m     <= w_b_mag;
        // A zero-divisor divide keeps the raw dividend for HI.
        r_p     <= {{WIDTH{1'b0}}, (w_div_zero ? a : w_a_mag)};
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dbz   <= w_div_zero;
        md_dbz  <= 1'b0;
      end else if (w_in_run) begin
        r_p     <= r_op[1] ? w_div_next : w_mul_next;
        r_count <= r_count + 1'b1;
      end else if (w_in_fix) begin
        md_done <= 1'b1;
        md_dbz  <= r_dbz;
        if (r_dbz) begin
          hi <= r_p[WIDTH-1:0];
          lo <= '1;
        end else if (r_op[1]) begin
          hi <= w_rem_fix;
          lo <= w_quo_fix;
        end else begin
          hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_alu_md
// Purpose  : Self-checking bench for ex_alu_md (WIDTH=32 and WIDTH=8
//            instances) against a behavioural arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_alu_md;

  logic        clk;
  logic        rst_n;

  // WIDTH=32 instance
  logic [31:0] a, b, result, hi, lo;
  logic [2:0]  control;
  logic        in_valid, zero, out_valid;
  logic        md_start, md_busy, md_done, md_dbz;
  logic [1:0]  md_op;

  // WIDTH=8 instance
  logic [7:0]  a8, b8, res8, hi8, lo8;
  logic [2:0]  ctl8;
  logic        iv8, z8, ov8, st8, busy8, done8, dbz8;
  logic [1:0]  op8;

  int errors = 0;
  int checks = 0;

  // Last committed / pending expected values for the 32-bit unit
  logic [31:0] exp_hi, exp_lo, exp_res;
  logic        exp_dbz, exp_zero;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_dbz;
  int          pend_lat;

  ex_alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .control(control),
    .in_valid(in_valid), .result(result), .zero(zero), .out_valid(out_valid),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
    .hi(hi), .lo(lo), .md_dbz(md_dbz)
  );

  ex_alu_md #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .control(ctl8),
    .in_valid(iv8), .result(res8), .zero(z8), .out_valid(ov8),
    .md_start(st8), .md_op(op8), .md_busy(busy8), .md_done(done8),
    .hi(hi8), .lo(lo8), .md_dbz(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(input int w, input logic [63:0] x);
    longint t;
    t = longint'(x << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic [63:0] alu_ref(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic [2:0] ctl);
    logic [63:0] r;
`ifdef ALU_SHIFT_EN
    int sh;
    sh = int'(av[5:0]) % w;
`endif
    case (ctl)
      3'b000:  r = av & bv;
      3'b001:  r = av | bv;
      3'b010:  r = av + bv;
      3'b110:  r = av - bv;
      3'b111:  r = (sx(w, av) < sx(w, bv)) ? 64'd1 : 64'd0;
`ifdef ALU_SHIFT_EN
      3'b011:  r = bv << sh;
      3'b100:  r = bv >> sh;
      3'b101:  r = 64'(sx(w, bv) >>> sh);
`endif
      default: r = 64'd0;
    endcase
    return r & mask(w);
  endfunction

  task automatic md_ref(input int w, input logic [1:0] op, input logic [63:0] av,
                        input logic [63:0] bv, output logic [63:0] eh,
                        output logic [63:0] el, output logic ed, output int lat);
    longint p, q, r;
    logic [63:0] up, m;
    m   = mask(w);
    ed  = 1'b0;
    lat = w + 1;
    eh  = 64'd0;
    el  = 64'd0;
    if (op[1] && bv == 64'd0) begin
      eh = av; el = m; ed = 1'b1; lat = 1;
    end else begin
      case (op)
        2'b00: begin p = sx(w, av) * sx(w, bv); el = 64'(p) & m; eh = (64'(p) >> w) & m; end
        2'b01: begin up = av * bv; el = up & m; eh = (up >> w) & m; end
        2'b10: begin q = sx(w, av) / sx(w, bv); r = sx(w, av) % sx(w, bv);
                     el = 64'(q) & m; eh = 64'(r) & m; end
        default: begin el = (av / bv) & m; eh = (av % bv) & m; end
      endcase
    end
  endtask

  // --------------------------------------------------------------- helpers
  task automatic alu_step(input logic [31:0] av, input logic [31:0] bv,
                          input logic [2:0] ctl, input logic iv, input string tag);
    logic [63:0] t;
    a = av; b = bv; control = ctl; in_valid = iv;
    if (iv) begin
      t = alu_ref(32, {32'd0, av}, {32'd0, bv}, ctl);
      exp_res  = t[31:0];
      exp_zero = (t == 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (result !== exp_res || zero !== exp_zero || out_valid !== iv) begin
      errors++;
      $display("FAIL %s ctl=%b: result=%h zero=%b ov=%b, expected %h %b %b",
               tag, ctl, result, zero, out_valid, exp_res, exp_zero, iv);
    end
  endtask

  task automatic start_md(input logic [1:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input string tag);
    logic [63:0] eh, el;
    md_ref(32, op, {32'd0, av}, {32'd0, bv}, eh, el, pend_dbz, pend_lat);
    pend_hi = eh[31:0];
    pend_lo = el[31:0];
    a = av; b = bv; md_op = op; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; a = $urandom; b = $urandom; md_op = 2'($urandom);
    checks++;
    if (md_busy !== 1'b1 || md_done !== 1'b0 || md_dbz !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b done=%b dbz=%b, expected 1 0 0",
               tag, md_busy, md_done, md_dbz);
    end
  endtask

  // Waits for md_done; k0 = cycles already spent since the start edge.
  task automatic wait_md(input string tag, input bit poke, input int k0);
    int k, busy_n;
    bit hold_ok;
    k = k0; busy_n = k0; hold_ok = 1'b1;
    while (md_done !== 1'b1 && k < 100) begin
      if (md_busy === 1'b1) busy_n++;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
      if (poke && k == 3) begin
        md_start = 1'b1; a = $urandom; b = $urandom; md_op = 2'($urandom);
      end else begin
        md_start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    md_start = 1'b0;
    checks++;
    if (md_done !== 1'b1 || k != pend_lat || busy_n != pend_lat) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles, busy %0d cycles, expected %0d",
               tag, k, busy_n, pend_lat);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s_hold: hi/lo changed while busy, expected %h/%h", tag, exp_hi, exp_lo);
    end
    checks++;
    if (hi !== pend_hi || lo !== pend_lo || md_dbz !== pend_dbz || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: hi=%h lo=%h dbz=%b busy=%b, expected %h %h %b 0",
               tag, hi, lo, md_dbz, md_busy, pend_hi, pend_lo, pend_dbz);
    end
    exp_hi = pend_hi; exp_lo = pend_lo; exp_dbz = pend_dbz;
  endtask

  task automatic run_md(input logic [1:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
    start_md(op, av, bv, tag);
    wait_md(tag, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (md_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: md_done=%b one cycle later, expected 0", tag, md_done);
    end
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 32'd0 || zero !== 1'b0 || out_valid !== 1'b0 || md_busy !== 1'b0 ||
        md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset32: res=%h z=%b ov=%b busy=%b done=%b hi=%h lo=%h dbz=%b, expected all 0",
               result, zero, out_valid, md_busy, md_done, hi, lo, md_dbz);
    end
    checks++;
    if (res8 !== 8'd0 || z8 !== 1'b0 || ov8 !== 1'b0 || busy8 !== 1'b0 ||
        done8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0 || dbz8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: res=%h hi=%h lo=%h busy=%b, expected all 0", res8, hi8, lo8, busy8);
    end
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0; exp_res = '0; exp_zero = 1'b0;
  endtask

  task automatic test_alu_directed;
    logic [31:0] ta [5] = '{32'd10, 32'd20, 32'hF0F0F0F0, 32'hAAAA5555, 32'hFFFFFFFB};
    logic [31:0] tb [5] = '{32'd15, 32'd20, 32'h0F0F0F0F, 32'h5555AAAA, 32'd3};
    logic [2:0]  tc [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [31:0] tr [5] = '{32'd25, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1};
    for (int i = 0; i < 5; i++) begin
      alu_step(ta[i], tb[i], tc[i], 1'b1, "alu_model");
      checks++;
      if (result !== tr[i] || zero !== (tr[i] == 32'd0)) begin
        errors++;
        $display("FAIL alu_directed[%0d]: result=%h zero=%b, expected %h %b",
                 i, result, zero, tr[i], (tr[i] == 32'd0));
      end
    end
    // No new operands: result and zero hold, out_valid drops
    alu_step(32'h12345678, 32'h1, 3'b010, 1'b0, "alu_hold");
  endtask

  task automatic test_alu_random;
    for (int i = 0; i < 40; i++)
      alu_step($urandom, $urandom, 3'($urandom), ($urandom_range(0, 3) != 0), "alu_rand");
  endtask

  task automatic test_md_directed;
    run_md(2'b00, 32'hFFFFFFFD, 32'd7, "mult");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_const: hi=%h lo=%h, expected FFFFFFFF FFFFFFEB", hi, lo);
    end
    run_md(2'b01, 32'hFFFFFFFD, 32'd7, "multu");
    run_md(2'b10, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_md(2'b11, 32'd100, 32'd7, "divu");
    run_md(2'b10, 32'd5, 32'd0, "div_zero");
    checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFFFFFF || md_dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_const: hi=%h lo=%h dbz=%b, expected 5 FFFFFFFF 1", hi, lo, md_dbz);
    end
    run_md(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_md(2'b11, 32'hDEADBEEF, 32'd0, "divu_zero");
    run_md(2'b00, 32'h80000000, 32'h80000000, "mult_minmin");
    run_md(2'b10, 32'd7, 32'hFFFFFFFE, "div_negdiv");
  endtask

  task automatic test_md_random;
    logic [31:0] bv;
    for (int i = 0; i < 8; i++) begin
      bv = $urandom;
      if ($urandom_range(0, 5) == 0) bv = 32'd0;
      else if ($urandom_range(0, 2) == 0) bv = 32'($urandom_range(1, 20));
      run_md(2'($urandom), $urandom, bv, "md_rand");
    end
  endtask

  task automatic test_busy_ignore;
    start_md(2'b10, 32'd1000, 32'd7, "busy_ign");
    wait_md("busy_ign", 1'b1, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    start_md(2'b00, 32'h00012345, 32'hFFFF0001, "b2b_first");
    wait_md("b2b_first", 1'b0, 0);
    start_md(2'b01, 32'hCAFEF00D, 32'h12345678, "b2b_second");
    wait_md("b2b_second", 1'b0, 0);
    @(negedge clk);
  endtask

  task automatic test_alu_during_md;
    start_md(2'b11, 32'hFFFFFFFF, 32'd3, "par");
    for (int i = 0; i < 3; i++)
      alu_step($urandom, $urandom, 3'($urandom), 1'b1, "par_alu");
    wait_md("par", 1'b0, 3);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    bit saw_done;
    start_md(2'b00, 32'h7, 32'h9, "rst_mid");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || md_busy !== 1'b0 || md_done !== 1'b0 ||
        md_dbz !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: hi=%h lo=%h busy=%b done=%b, expected 0 0 0 0",
               hi, lo, md_busy, md_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_res = '0; exp_zero = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done !== 1'b0 || md_busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rst_mid_quiet: unit became busy/done after abort, expected idle");
    end
  endtask

  task automatic test_width8;
    int k;
    logic [63:0] eh, el;
    logic ed;
    int lat;
    logic [7:0] want [3];
    logic [2:0] ctl [3] = '{3'b101, 3'b100, 3'b011};
`ifdef ALU_SHIFT_EN
    want = '{8'hF8, 8'h08, 8'h10};
`else
    want = '{8'h00, 8'h00, 8'h00};
`endif
    md_ref(8, 2'b01, 64'hFF, 64'hFF, eh, el, ed, lat);
    a8 = 8'hFF; b8 = 8'hFF; op8 = 2'b01; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'h3C; b8 = 8'h11;
    k = 0;
    while (done8 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done8 !== 1'b1 || k != lat || hi8 !== eh[7:0] || lo8 !== el[7:0] ||
        hi8 !== 8'hFE || lo8 !== 8'h01) begin
      errors++;
      $display("FAIL w8_multu: done=%b after %0d, hi=%h lo=%h, expected 9 cycles %h %h",
               done8, k, hi8, lo8, eh[7:0], el[7:0]);
    end
    for (int i = 0; i < 3; i++) begin
      a8 = 8'd4; b8 = 8'h81; ctl8 = ctl[i]; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      checks++;
      if (res8 !== want[i] || z8 !== (want[i] == 8'd0) || ov8 !== 1'b1) begin
        errors++;
        $display("FAIL w8_shift ctl=%b: result=%h zero=%b ov=%b, expected %h %b 1",
                 ctl[i], res8, z8, ov8, want[i], (want[i] == 8'd0));
      end
    end
    a8 = 8'hF0; b8 = 8'h20; ctl8 = 3'b010; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    checks++;
    if (res8 !== 8'h10 || z8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_add_wrap: result=%h zero=%b, expected 10 0", res8, z8);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; control = '0; in_valid = 1'b0; md_start = 1'b0; md_op = '0;
    a8 = '0; b8 = '0; ctl8 = '0; iv8 = 1'b0; st8 = 1'b0; op8 = '0;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_md_directed();
    test_md_random();
    test_busy_ignore();
    test_back_to_back();
    test_alu_during_md();
    test_reset_mid_run();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
